// File: rtl/memory_writeback.sv
// memory_writeback: final pipeline stage committing register writes and performing stores via a three-phase bus handshake.
// Ports:
//   clk, reset (async, active-low)
//   upstream slot: opcodeValidIn, canWritebackIn, opcodeIn, currentRipIn, instructionLengthIn,
//     destReg*In, destRegSpecial*In, isMemoryAccessDestIn, memoryAddressDestIn, storeDataIn; wbStallOut back
//   register file: regWrite{En,Addr,Data}Out, regWriteSpecial{En,Addr,Data}Out
//   retire: retireValidOut, nextRipOut
//   data-cache bus: reqcycOut/reqackIn/reqOut/reqtagOut, respcycIn/respackOut
module memory_writeback #(
    parameter int TAG_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             opcodeValidIn,
    input  logic             canWritebackIn,
    input  logic [7:0]       opcodeIn,
    input  logic [63:0]      currentRipIn,
    input  logic [31:0]      instructionLengthIn,
    input  logic [3:0]       destRegIn,
    input  logic             destRegValidIn,
    input  logic [63:0]      destRegValueIn,
    input  logic [3:0]       destRegSpecialIn,
    input  logic             destRegSpecialValidIn,
    input  logic [63:0]      destRegSpecialValueIn,
    input  logic             isMemoryAccessDestIn,
    input  logic [63:0]      memoryAddressDestIn,
    input  logic [63:0]      storeDataIn,
    output logic             wbStallOut,
    output logic             regWriteEnOut,
    output logic [3:0]       regWriteAddrOut,
    output logic [63:0]      regWriteDataOut,
    output logic             regWriteSpecialEnOut,
    output logic [3:0]       regWriteSpecialAddrOut,
    output logic [63:0]      regWriteSpecialDataOut,
    output logic             retireValidOut,
    output logic [63:0]      nextRipOut,
    output logic             reqcycOut,
    input  logic             reqackIn,
    output logic [63:0]      reqOut,
    output logic [TAG_W-1:0] reqtagOut,
    input  logic             respcycIn,
    output logic             respackOut
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    typedef struct packed {
        logic [3:0]  dst;
        logic        dst_v;
        logic [63:0] dst_val;
        logic [3:0]  sp;
        logic        sp_v;
        logic [63:0] sp_val;
        logic [63:0] next_rip;
        logic [63:0] sdata;
    } commit_t;
    state_t state_q, state_d;
    commit_t cap_q, cap_d, in_c, src;
    logic accept, store_acc, resp_done, commit;
    logic gen_en_q, gen_en_d, sp_en_q, sp_en_d, retire_q, retire_d;
    logic reqcyc_q, reqcyc_d, respack_q, respack_d;
    logic [3:0] gen_addr_q, gen_addr_d, sp_addr_q, sp_addr_d;
    logic [63:0] gen_data_q, gen_data_d, sp_data_q, sp_data_d;
    logic [63:0] next_rip_q, next_rip_d, req_q, req_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    always_comb begin
        in_c = '{dst: destRegIn, dst_v: destRegValidIn, dst_val: destRegValueIn,
                 sp: destRegSpecialIn, sp_v: destRegSpecialValidIn, sp_val: destRegSpecialValueIn,
                 next_rip: currentRipIn + {32'd0, instructionLengthIn}, sdata: storeDataIn};
        accept = state_q == IDLE && opcodeValidIn && canWritebackIn;
        store_acc = accept && isMemoryAccessDestIn;
        resp_done = state_q == RESP && respcycIn;
        wbStallOut = store_acc || state_q == ADDR || state_q == DATA || (state_q == RESP && !respcycIn);
        // Non-stores commit straight from the inputs; stores commit from the captured copy.
        src = state_q == IDLE ? in_c : cap_q;
        commit = (accept && !isMemoryAccessDestIn) || resp_done;
        state_d = store_acc ? ADDR :
                  state_q == ADDR && reqackIn ? DATA :
                  state_q == DATA && reqackIn ? RESP :
                  resp_done ? IDLE : state_q;
        cap_d = accept ? in_c : cap_q;
        reqcyc_d = store_acc ? 1'b1 : state_q == DATA && reqackIn ? 1'b0 : reqcyc_q;
        req_d = store_acc ? memoryAddressDestIn : state_q == ADDR && reqackIn ? cap_q.sdata : req_q;
        tag_d = store_acc ? TAG_W'({2'b11, opcodeIn}) : tag_q;
        respack_d = resp_done;
        // Same-index dual write: the special port wins.
        gen_en_d = commit && src.dst_v && !(src.sp_v && src.sp == src.dst);
        gen_addr_d = commit ? src.dst : gen_addr_q;
        gen_data_d = commit ? src.dst_val : gen_data_q;
        sp_en_d = commit && src.sp_v;
        sp_addr_d = commit ? src.sp : sp_addr_q;
        sp_data_d = commit ? src.sp_val : sp_data_q;
        retire_d = commit;
        next_rip_d = commit ? src.next_rip : next_rip_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cap_q <= '0;
            reqcyc_q <= 1'b0;
            req_q <= '0;
            tag_q <= '0;
            respack_q <= 1'b0;
            gen_en_q <= 1'b0;
            gen_addr_q <= '0;
            gen_data_q <= '0;
            sp_en_q <= 1'b0;
            sp_addr_q <= '0;
            sp_data_q <= '0;
            retire_q <= 1'b0;
            next_rip_q <= '0;
        end else begin
            state_q <= state_d;
            cap_q <= cap_d;
            reqcyc_q <= reqcyc_d;
            req_q <= req_d;
            tag_q <= tag_d;
            respack_q <= respack_d;
            gen_en_q <= gen_en_d;
            gen_addr_q <= gen_addr_d;
            gen_data_q <= gen_data_d;
            sp_en_q <= sp_en_d;
            sp_addr_q <= sp_addr_d;
            sp_data_q <= sp_data_d;
            retire_q <= retire_d;
            next_rip_q <= next_rip_d;
        end
    end
    assign regWriteEnOut = gen_en_q;
    assign regWriteAddrOut = gen_addr_q;
    assign regWriteDataOut = gen_data_q;
    assign regWriteSpecialEnOut = sp_en_q;
    assign regWriteSpecialAddrOut = sp_addr_q;
    assign regWriteSpecialDataOut = sp_data_q;
    assign retireValidOut = retire_q;
    assign nextRipOut = next_rip_q;
    assign reqcycOut = reqcyc_q;
    assign reqOut = req_q;
    assign reqtagOut = tag_q;
    assign respackOut = respack_q;
endmodule

// File: tb/tb_memory_writeback.sv
// tb_memory_writeback: directed self-checking bench for memory_writeback.
module tb_memory_writeback;
    logic clk = 1'b0, reset = 1'b0;
    logic opcodeValidIn = 0, canWritebackIn = 0, isMemoryAccessDestIn = 0;
    logic [7:0] opcodeIn = 0;
    logic [63:0] currentRipIn = 0, destRegValueIn = 0, destRegSpecialValueIn = 0;
    logic [63:0] memoryAddressDestIn = 0, storeDataIn = 0;
    logic [31:0] instructionLengthIn = 0;
    logic [3:0] destRegIn = 0, destRegSpecialIn = 0;
    logic destRegValidIn = 0, destRegSpecialValidIn = 0;
    logic reqackIn = 0, respcycIn = 0;
    logic wbStallOut, regWriteEnOut, regWriteSpecialEnOut, retireValidOut, reqcycOut, respackOut;
    logic [3:0] regWriteAddrOut, regWriteSpecialAddrOut;
    logic [63:0] regWriteDataOut, regWriteSpecialDataOut, nextRipOut, reqOut;
    logic [9:0] reqtagOut;
    int n_chk = 0, n_pass = 0;
    memory_writeback #(.TAG_W(10)) dut (
        .clk(clk), .reset(reset),
        .opcodeValidIn(opcodeValidIn), .canWritebackIn(canWritebackIn), .opcodeIn(opcodeIn),
        .currentRipIn(currentRipIn), .instructionLengthIn(instructionLengthIn),
        .destRegIn(destRegIn), .destRegValidIn(destRegValidIn), .destRegValueIn(destRegValueIn),
        .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
        .destRegSpecialValueIn(destRegSpecialValueIn),
        .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
        .storeDataIn(storeDataIn), .wbStallOut(wbStallOut),
        .regWriteEnOut(regWriteEnOut), .regWriteAddrOut(regWriteAddrOut), .regWriteDataOut(regWriteDataOut),
        .regWriteSpecialEnOut(regWriteSpecialEnOut), .regWriteSpecialAddrOut(regWriteSpecialAddrOut),
        .regWriteSpecialDataOut(regWriteSpecialDataOut),
        .retireValidOut(retireValidOut), .nextRipOut(nextRipOut),
        .reqcycOut(reqcycOut), .reqackIn(reqackIn), .reqOut(reqOut), .reqtagOut(reqtagOut),
        .respcycIn(respcycIn), .respackOut(respackOut)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic st, input logic [7:0] op, input logic [63:0] rip, input logic [31:0] len,
                         input logic [3:0] d, input logic dv, input logic [63:0] dval,
                         input logic [3:0] s, input logic sv, input logic [63:0] sval,
                         input logic [63:0] a, input logic [63:0] sd);
        opcodeValidIn = 1; canWritebackIn = 1; isMemoryAccessDestIn = st; opcodeIn = op;
        currentRipIn = rip; instructionLengthIn = len;
        destRegIn = d; destRegValidIn = dv; destRegValueIn = dval;
        destRegSpecialIn = s; destRegSpecialValidIn = sv; destRegSpecialValueIn = sval;
        memoryAddressDestIn = a; storeDataIn = sd;
        #1;
    endtask
    initial begin
        #2;
        chk("rst_reqcyc", reqcycOut, 0);
        chk("rst_retire", retireValidOut, 0);
        chk("rst_en", regWriteEnOut, 0);
        chk("rst_sp_en", regWriteSpecialEnOut, 0);
        chk("rst_nrip", nextRipOut, 0);
        chk("rst_tag", reqtagOut, 0);
        chk("rst_stall", wbStallOut, 0);
        tick(); tick();
        reset = 1;
        // reqackIn in IDLE must be ignored
        reqackIn = 1;
        tick();
        chk("idle_ack_ign", reqcycOut, 0);
        reqackIn = 0;
        // three back-to-back non-stores
        drive(0, 8'h01, 64'h1000, 3, 4'd1, 1, 64'h55, 4'd0, 0, 0, 0, 0);
        chk("ns0_stall", wbStallOut, 0);
        tick();
        chk("ns0_en", regWriteEnOut, 1);
        chk("ns0_ret", retireValidOut, 1);
        chk("ns0_nrip", nextRipOut, 64'h1003);
        chk("ns0_addr", regWriteAddrOut, 1);
        chk("ns0_data", regWriteDataOut, 64'h55);
        drive(0, 8'h01, 64'h1003, 2, 4'd1, 1, 64'h55, 4'd0, 0, 0, 0, 0);
        chk("ns1_stall", wbStallOut, 0);
        tick();
        chk("ns1_en", regWriteEnOut, 1);
        chk("ns1_ret", retireValidOut, 1);
        chk("ns1_nrip", nextRipOut, 64'h1005);
        drive(0, 8'h01, 64'h1005, 4, 4'd1, 1, 64'h55, 4'd0, 0, 0, 0, 0);
        chk("ns2_stall", wbStallOut, 0);
        tick();
        chk("ns2_en", regWriteEnOut, 1);
        chk("ns2_ret", retireValidOut, 1);
        chk("ns2_nrip", nextRipOut, 64'h1009);
        opcodeValidIn = 0;
        tick();
        chk("ns_end_ret", retireValidOut, 0);
        chk("ns_end_en", regWriteEnOut, 0);
        // nextRip wraps modulo 2^64; no write requested keeps enable low
        drive(0, 8'h02, 64'hFFFF_FFFF_FFFF_FFFE, 4, 4'd2, 0, 64'h9, 4'd0, 0, 0, 0, 0);
        tick();
        chk("wrap_nrip", nextRipOut, 64'h2);
        chk("wrap_en", regWriteEnOut, 0);
        // same-index dual write: special wins
        drive(0, 8'h03, 64'h10, 1, 4'd4, 1, 64'h1, 4'd4, 1, 64'h2, 0, 0);
        tick();
        chk("dual_gen_en", regWriteEnOut, 0);
        chk("dual_sp_en", regWriteSpecialEnOut, 1);
        chk("dual_sp_data", regWriteSpecialDataOut, 64'h2);
        // different indices: both ports fire
        drive(0, 8'h03, 64'h10, 1, 4'd3, 1, 64'h7, 4'd4, 1, 64'h8, 0, 0);
        tick();
        chk("diff_gen_en", regWriteEnOut, 1);
        chk("diff_sp_en", regWriteSpecialEnOut, 1);
        opcodeValidIn = 0;
        tick();
        // zero-wait store
        drive(1, 8'h89, 64'h3000, 2, 4'd0, 0, 0, 4'd0, 0, 0, 64'h2000, 64'hDEADBEEF);
        chk("st_acc_stall", wbStallOut, 1);
        tick();
        chk("st_a_reqcyc", reqcycOut, 1);
        chk("st_a_req", reqOut, 64'h2000);
        chk("st_a_tag", reqtagOut, 10'h389);
        chk("st_a_ret", retireValidOut, 0);
        reqackIn = 1;
        #1 chk("st_a_stall", wbStallOut, 1);
        tick();
        chk("st_d_req", reqOut, 64'hDEADBEEF);
        chk("st_d_reqcyc", reqcycOut, 1);
        chk("st_d_stall", wbStallOut, 1);
        tick();
        chk("st_r_reqcyc", reqcycOut, 0);
        reqackIn = 0; respcycIn = 1; opcodeValidIn = 0;
        #1 chk("st_r_stall", wbStallOut, 0);
        chk("st_r_ret", retireValidOut, 0);
        tick();
        chk("st_ret", retireValidOut, 1);
        chk("st_nrip", nextRipOut, 64'h3002);
        chk("st_respack", respackOut, 1);
        chk("st_en", regWriteEnOut, 0);
        respcycIn = 0;
        tick();
        chk("st_ret_clr", retireValidOut, 0);
        chk("st_respack_clr", respackOut, 0);
        // PUSH-like store with delayed acks and response
        drive(1, 8'h50, 64'h4000, 1, 4'd0, 0, 0, 4'd4, 1, 64'h7FF8, 64'h7FF8, 64'h1234);
        tick();
        chk("push_acc_sp_en", regWriteSpecialEnOut, 0);
        chk("push_acc_ret", retireValidOut, 0);
        for (int i = 0; i < 3; i++) begin
            chk("push_a_req", reqOut, 64'h7FF8);
            chk("push_a_tag", reqtagOut, 10'h350);
            chk("push_a_stall", wbStallOut, 1);
            tick();
        end
        reqackIn = 1;
        tick();
        reqackIn = 0;
        for (int i = 0; i < 3; i++) begin
            chk("push_d_req", reqOut, 64'h1234);
            chk("push_d_reqcyc", reqcycOut, 1);
            tick();
        end
        reqackIn = 1;
        tick();
        reqackIn = 0;
        for (int i = 0; i < 5; i++) begin
            chk("push_r_stall", wbStallOut, 1);
            chk("push_r_sp_en", regWriteSpecialEnOut, 0);
            chk("push_r_respack", respackOut, 0);
            tick();
        end
        respcycIn = 1; opcodeValidIn = 0;
        #1 chk("push_rc_stall", wbStallOut, 0);
        tick();
        respcycIn = 0;
        chk("push_ret", retireValidOut, 1);
        chk("push_sp_en", regWriteSpecialEnOut, 1);
        chk("push_sp_addr", regWriteSpecialAddrOut, 4);
        chk("push_sp_data", regWriteSpecialDataOut, 64'h7FF8);
        chk("push_nrip", nextRipOut, 64'h4001);
        chk("push_respack", respackOut, 1);
        tick();
        chk("push_respack_clr", respackOut, 0);
        // reset mid-DATA abandons the store
        drive(1, 8'h89, 64'h5000, 2, 4'd1, 1, 64'h66, 4'd0, 0, 0, 64'h6000, 64'h77);
        tick();
        reqackIn = 1;
        tick();
        reqackIn = 0; opcodeValidIn = 0;
        chk("mid_reqcyc_pre", reqcycOut, 1);
        #2 reset = 0;
        #1;
        chk("mid_reqcyc", reqcycOut, 0);
        chk("mid_stall", wbStallOut, 0);
        chk("mid_req", reqOut, 0);
        chk("mid_tag", reqtagOut, 0);
        respcycIn = 1;
        tick();
        reset = 1;
        tick();
        chk("mid_ret", retireValidOut, 0);
        chk("mid_en", regWriteEnOut, 0);
        chk("mid_respack", respackOut, 0);
        chk("mid_stall2", wbStallOut, 0);
        respcycIn = 0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memory_writeback.md
# memory_writeback

Final pipeline stage, directly downstream of the memory stage. Accepts one instruction per cycle from the memory stage and commits its results. Results go to the register file through two write ports: general and special destination. Stores are performed through a three-phase write handshake on the data-cache core bus, and the upstream pipeline is held on `wbStallOut` while a store is outstanding. Each committed instruction produces a one-cycle retire pulse carrying the next RIP.

## Interface
Parameters:
- `TAG_W`, 10: request tag width; tag = {write=1, memory=1, opcode[0:7]}.

Ports:
- `clk`  in  1  pipeline clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it immediately forces the reset state.
- `opcodeValidIn`  in  1  upstream slot holds an instruction.
- `canWritebackIn`  in  1  memory stage finished (its isMemorySuccessful).
- `opcodeIn`  in  8  opcode, placed in store tag.
- `currentRipIn`  in  64  RIP of instruction.
- `instructionLengthIn`  in  32  byte length of instruction.
- `destRegIn`  in  4  general destination register.
- `destRegValidIn`  in  1  general destination write requested.
- `destRegValueIn`  in  64  general destination value.
- `destRegSpecialIn`  in  4  special destination register (e.g. RSP update).
- `destRegSpecialValidIn`  in  1  special write requested.
- `destRegSpecialValueIn`  in  64  special destination value.
- `isMemoryAccessDestIn`  in  1  instruction stores to memory.
- `memoryAddressDestIn`  in  64  store address.
- `storeDataIn`  in  64  store data.
- `wbStallOut`  out  1  combinational; upstream must hold while high.
- `regWriteEnOut`, `regWriteAddrOut`, `regWriteDataOut`  out  1/4/64  general write port.
- `regWriteSpecialEnOut`, `regWriteSpecialAddrOut`, `regWriteSpecialDataOut`  out  1/4/64  special write port.
- `retireValidOut`  out  1  one-cycle commit pulse.
- `nextRipOut`  out  64  currentRip + instructionLength (zero-extended, mod 2^64) of retired instruction.
- `reqcycOut`  out  1  bus request valid.
- `reqackIn`  in  1  bus accepted current beat.
- `reqOut`  out  64  address beat, then data beat.
- `reqtagOut`  out  TAG_W  request tag.
- `respcycIn`  in  1  store completion response.
- `respackOut`  out  1  response acknowledge.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- Accept condition: IDLE && opcodeValidIn && canWritebackIn. Instruction fields are captured into internal registers on the accepting edge.
- Non-store accept: the state remains IDLE. At the next edge the block drives:
  - the requested write enables, with addresses and data;
  - `retireValidOut`=1 and `nextRipOut`.
  - All of these are registered, held exactly one cycle, then cleared.
  - Back-to-back non-store instructions retire every cycle.
- Store accept: the FSM moves to ADDR and drives `reqcycOut`=1, `reqOut`=address, `reqtagOut`={1,1,opcode}.
- ADDR with `reqackIn`: `reqOut`<=store data, `reqcycOut` stays 1, move to DATA.
- DATA with `reqackIn`: `reqcycOut`<=0, move to RESP.
- RESP with `respcycIn`:
  - `respackOut`<=1 for one cycle and the FSM returns to IDLE.
  - On the same edge the captured register writes and the retire pulse are issued for one cycle.
- `reqackIn` outside ADDR/DATA and `respcycIn` outside RESP are ignored.
- `wbStallOut`=1 in these cases:
  - IDLE with a store accept that cycle;
  - ADDR or DATA;
  - RESP without `respcycIn`.
- `wbStallOut`=0 otherwise, so a new instruction can be accepted the cycle after a store retires.
- If both write ports are requested with the same register index, the general port is suppressed and the special port wins.
- A write port with its valid low keeps its enable at 0. Address and data of a disabled port are don't-care.

## Timing
- Reset values:
  - state IDLE;
  - all enables, `retireValidOut`, `reqcycOut`, `respackOut` = 0;
  - all data, address, tag and RIP outputs = 0.
- Non-store latency: accept edge + 1 cycle to register write and retire.
- Store latency: 1 (addr) + ack waits + 1 (data) + ack waits + response wait + 1.
  - Minimum 4 cycles from accept to retire pulse, with ack and response each on their first eligible cycle.
- `reqOut` and `reqtagOut` are stable while `reqcycOut`=1 and no ack has been received.
- Reset asserted mid-store: outputs go to reset values at once and the store is abandoned. No retire or register write follows.

## Test plan
- Reset: assert `reset`=0 mid-DATA -> `reqcycOut`=0, `wbStallOut`=0, state IDLE, no retire.
- Non-store stream, three instructions back-to-back:
  - stimulus: rip 0x1000 len 3, dest R1=0x55;
  - required: `regWriteEnOut` and `retireValidOut` pulse in 3 consecutive cycles, first `nextRipOut`=0x1003, `wbStallOut` never high.
- Store, zero-wait bus: addr 0x2000, data 0xDEADBEEF, opcode 0x89.
  - Beat 1: `reqOut`=0x2000, tag=0x389.
  - Beat 2: `reqOut`=0xDEADBEEF.
  - Retire pulse 4 cycles after accept; `wbStallOut` high for exactly the accept cycle plus ADDR and DATA.
- Store with 3-cycle `reqackIn` delay on each beat and 5-cycle response delay:
  - beats held stable throughout;
  - `respackOut` pulses once;
  - stall ends in the `respcycIn` cycle.
- PUSH-like store: special RSP=0x7FF8 plus store -> special write and retire fire only on the RESP edge, not at accept.
- Same-index dual write, R4 general=1 and special=2 -> only the special port is enabled, with data 2.
